// File: rtl/arcade_ctrl_mapper.sv
// Arcade control conditioner: maps user_io joystick words onto arcade core
// inputs with player swap/merge, rotation, SOCD cleaning, coin stretching,
// autofire and selectable output polarity. Two register stages.

// Per-player stage 2: rotation, SOCD, coin stretch, autofire, output register.
module arcade_ctrl_player #(
    parameter int               FIRES      = 6,
    parameter int               COIN_W     = 20,
    parameter logic [COIN_W-1:0] COIN_MIN  = 20'd250000,
    parameter int               AF_W       = 18,
    parameter logic [AF_W-1:0]  AF_HALF    = 18'd100000,
    parameter int               ACTIVE_LOW = 0
) (
    input  logic             clk_sys,
    input  logic             RESET,
    input  logic [3:0]       btn_dir,      // {up,down,left,right} from stage 1
    input  logic [FIRES-1:0] btn_fire,
    input  logic             btn_start,
    input  logic             btn_coin,
    input  logic             rotate,
    input  logic [1:0]       orientation,
    input  logic [FIRES-1:0] af_mask,
    output logic [3:0]       dir,
    output logic [FIRES-1:0] fire,
    output logic             start,
    output logic             coin
);

    localparam int   OW  = FIRES + 6;
    localparam logic POL = (ACTIVE_LOW != 0);

    // last-pressed direction per axis; LO is right/down, HI is left/up
    typedef enum logic [1:0] {LP_NONE, LP_LO, LP_HI} last_t;
    typedef enum logic [1:0] {C_IDLE, C_ACTIVE, C_WAIT} coin_t;

    logic [3:0]        rot_dir;
    logic [3:0]        flip_dir;
    logic [3:0]        dir_q;
    logic [3:0]        dir_rise;
    logic [3:0]        socd_dir;
    last_t             last_q [2];
    last_t             last_d [2];

    coin_t             coin_st, coin_nx;
    logic [COIN_W-1:0] coin_cnt, coin_cnt_nx;
    logic              coin_q;

    logic [FIRES-1:0]  fire_q;
    logic [AF_W-1:0]   af_cnt, af_cnt_nx;
    logic              af_ph, af_ph_nx;
    logic [FIRES-1:0]  fire_d;

    logic [OW-1:0]     out_d, out_q;

    // 90-degree remap when rotate is set, then optional 180-degree flip
    always_comb begin
        rot_dir = btn_dir;
        if (rotate) begin
            if (!orientation[0])
                rot_dir = {btn_dir[1], btn_dir[0], btn_dir[2], btn_dir[3]};
            else
                rot_dir = {btn_dir[0], btn_dir[1], btn_dir[3], btn_dir[2]};
        end
        flip_dir = rot_dir;
        if (orientation[1])
            flip_dir = {rot_dir[2], rot_dir[3], rot_dir[0], rot_dir[1]};
        dir_rise = flip_dir & ~dir_q;
    end

    // SOCD: newest press wins, simultaneous press cancels, loser returns a cycle after winner release
    always_comb begin
        socd_dir = '0;
        for (int a = 0; a < 2; a++) begin
            last_d[a] = last_q[a];
            if (dir_rise[2*a] && dir_rise[2*a+1])
                last_d[a] = LP_NONE;
            else if (dir_rise[2*a])
                last_d[a] = LP_LO;
            else if (dir_rise[2*a+1])
                last_d[a] = LP_HI;
            else if (last_q[a] == LP_LO && !flip_dir[2*a])
                last_d[a] = LP_NONE;
            else if (last_q[a] == LP_HI && !flip_dir[2*a+1])
                last_d[a] = LP_NONE;
            else if (last_q[a] == LP_NONE && flip_dir[2*a] && !flip_dir[2*a+1])
                last_d[a] = LP_LO;
            else if (last_q[a] == LP_NONE && flip_dir[2*a+1] && !flip_dir[2*a])
                last_d[a] = LP_HI;
            socd_dir[2*a]   = flip_dir[2*a]   && (last_d[a] == LP_LO);
            socd_dir[2*a+1] = flip_dir[2*a+1] && (last_d[a] == LP_HI);
        end
    end

    // coin FSM next state: one fixed-length pulse per press, no retrigger
    always_comb begin
        coin_nx     = coin_st;
        coin_cnt_nx = coin_cnt;
        case (coin_st)
            C_IDLE: begin
                if (btn_coin && !coin_q) begin
                    coin_nx     = C_ACTIVE;
                    coin_cnt_nx = COIN_MIN - 1'b1;
                end
            end
            C_ACTIVE: begin
                if (coin_cnt == '0)
                    coin_nx = C_WAIT;
                else
                    coin_cnt_nx = coin_cnt - 1'b1;
            end
            C_WAIT: begin
                if (!btn_coin)
                    coin_nx = C_IDLE;
            end
            default: coin_nx = C_IDLE;
        endcase
    end

    // autofire: restart on any new masked press so the first shot is immediate
    always_comb begin
        af_cnt_nx = af_cnt;
        af_ph_nx  = af_ph;
        if (|(btn_fire & ~fire_q & af_mask)) begin
            af_cnt_nx = '0;
            af_ph_nx  = 1'b1;
        end else if (|(btn_fire & af_mask)) begin
            if (af_cnt == AF_HALF - 1'b1) begin
                af_cnt_nx = '0;
                af_ph_nx  = ~af_ph;
            end else begin
                af_cnt_nx = af_cnt + 1'b1;
            end
        end else begin
            af_cnt_nx = '0;
            af_ph_nx  = 1'b1;
        end
        fire_d = btn_fire & ~(af_mask & {FIRES{~af_ph_nx}});
        out_d  = {socd_dir, fire_d, btn_start, coin_nx == C_ACTIVE};
    end

    // state registers for edge detection, SOCD, coin and autofire
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            dir_q    <= '0;
            coin_st  <= C_IDLE;
            coin_cnt <= '0;
            coin_q   <= 1'b0;
            fire_q   <= '0;
            af_cnt   <= '0;
            af_ph    <= 1'b0;
            for (int a = 0; a < 2; a++) last_q[a] <= LP_NONE;
        end else begin
            dir_q    <= flip_dir;
            coin_st  <= coin_nx;
            coin_cnt <= coin_cnt_nx;
            coin_q   <= btn_coin;
            fire_q   <= btn_fire;
            af_cnt   <= af_cnt_nx;
            af_ph    <= af_ph_nx;
            for (int a = 0; a < 2; a++) last_q[a] <= last_d[a];
        end
    end

    // output register; polarity applied only here
    always_ff @(posedge clk_sys) begin
        if (RESET) out_q <= {OW{POL}};
        else       out_q <= out_d ^ {OW{POL}};
    end

    assign dir   = out_q[OW-1 -: 4];
    assign fire  = out_q[2 +: FIRES];
    assign start = out_q[1];
    assign coin  = out_q[0];

endmodule

module arcade_ctrl_mapper #(
    parameter int               PLAYERS    = 2,
    parameter int               FIRES      = 6,
    parameter int               COIN_W     = 20,
    parameter logic [COIN_W-1:0] COIN_MIN  = 20'd250000,
    parameter int               AF_W       = 18,
    parameter logic [AF_W-1:0]  AF_HALF    = 18'd100000,
    parameter int               ACTIVE_LOW = 0
) (
    input  logic                     clk_sys,
    input  logic                     RESET,
    input  logic [PLAYERS*16-1:0]    joy_in,
    input  logic                     rotate,
    input  logic [1:0]               orientation,
    input  logic                     joyswap,
    input  logic                     oneplayer,
    input  logic [FIRES-1:0]         af_mask,
    output logic [PLAYERS*4-1:0]     dir_out,
    output logic [PLAYERS*FIRES-1:0] fire_out,
    output logic [PLAYERS-1:0]       start_out,
    output logic [PLAYERS-1:0]       coin_out
);

    // word bits that feed the conditioner; the rest are ignored
    localparam logic [15:0] USED = 16'h300F | (16'((1 << FIRES) - 1) << 4);

    logic [PLAYERS-1:0][15:0] joy_w;
    logic [PLAYERS-1:0][15:0] map_w;
    logic [PLAYERS-1:0][15:0] s1_q;
    logic [PLAYERS-1:0]       unused_s1;

    // split the flat bus into per-player words
    always_comb begin
        for (int p = 0; p < PLAYERS; p++) begin
            joy_w[p]     = joy_in[16*p +: 16];
            unused_s1[p] = ^(s1_q[p] & ~USED);
        end
    end

    generate
        if (PLAYERS > 1) begin : g_multi
            logic [PLAYERS-1:0][15:0] swp_w;
            // swap players 0/1 first, then fold player 1 into player 0
            always_comb begin
                swp_w = joy_w;
                if (joyswap) begin
                    swp_w[0] = joy_w[1];
                    swp_w[1] = joy_w[0];
                end
                map_w = swp_w;
                if (oneplayer) begin
                    map_w[0] = swp_w[0] | swp_w[1];
                    map_w[1] = '0;
                end
            end
        end else begin : g_single
            logic unused_ctrl;
            assign unused_ctrl = joyswap ^ oneplayer;
            assign map_w       = joy_w;
        end
    endgenerate

    // stage 1: register the swapped/merged player words
    always_ff @(posedge clk_sys) begin
        if (RESET) s1_q <= '0;
        else       s1_q <= map_w;
    end

    generate
        for (genvar p = 0; p < PLAYERS; p++) begin : g_player
            arcade_ctrl_player #(
                .FIRES      (FIRES),
                .COIN_W     (COIN_W),
                .COIN_MIN   (COIN_MIN),
                .AF_W       (AF_W),
                .AF_HALF    (AF_HALF),
                .ACTIVE_LOW (ACTIVE_LOW)
            ) u_player (
                .clk_sys     (clk_sys),
                .RESET       (RESET),
                .btn_dir     (s1_q[p][3:0]),
                .btn_fire    (s1_q[p][4 +: FIRES]),
                .btn_start   (s1_q[p][12]),
                .btn_coin    (s1_q[p][13]),
                .rotate      (rotate),
                .orientation (orientation),
                .af_mask     (af_mask),
                .dir         (dir_out[4*p +: 4]),
                .fire        (fire_out[FIRES*p +: FIRES]),
                .start       (start_out[p]),
                .coin        (coin_out[p])
            );
        end
    endgenerate

endmodule

// File: tb/tb_arcade_ctrl_mapper.sv
// Bench for arcade_ctrl_mapper: static vectors, multi-cycle corner sequences
// and randomized traffic against an event-level reference model.
module tb_arcade_ctrl_mapper;

    localparam int PLAYERS    = 2;
    localparam int FIRES      = 6;
    localparam int COIN_MIN_I = 8;
    localparam int AF_HALF_I  = 4;

    logic        clk_sys = 1'b0;
    logic        RESET;
    logic [31:0] joy_in;
    logic        rotate;
    logic [1:0]  orientation;
    logic        joyswap, oneplayer;
    logic [5:0]  af_mask;
    logic [7:0]  dir_out;
    logic [11:0] fire_out;
    logic [1:0]  start_out, coin_out;

    // active-high views of the inverted outputs
    logic [7:0]  dir_h;
    logic [11:0] fire_h;
    logic [1:0]  start_h, coin_h;
    assign dir_h   = ~dir_out;
    assign fire_h  = ~fire_out;
    assign start_h = ~start_out;
    assign coin_h  = ~coin_out;

    arcade_ctrl_mapper #(
        .PLAYERS(PLAYERS), .FIRES(FIRES), .COIN_W(20), .COIN_MIN(20'(COIN_MIN_I)),
        .AF_W(18), .AF_HALF(18'(AF_HALF_I)), .ACTIVE_LOW(1)
    ) dut (
        .clk_sys(clk_sys), .RESET(RESET), .joy_in(joy_in), .rotate(rotate),
        .orientation(orientation), .joyswap(joyswap), .oneplayer(oneplayer),
        .af_mask(af_mask), .dir_out(dir_out), .fire_out(fire_out),
        .start_out(start_out), .coin_out(coin_out)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // ---------------- reference model ----------------
    logic [15:0]      m_s1 [PLAYERS];
    logic [3:0]       m_pd [PLAYERS];
    logic [3:0]       m_po [PLAYERS];
    int               m_t  [PLAYERS][4];
    logic [FIRES-1:0] m_pf [PLAYERS];
    int               m_age[PLAYERS];
    logic             m_pc [PLAYERS];
    int               m_left[PLAYERS];
    bit               m_dead[PLAYERS], m_wlow[PLAYERS];
    int               m_cyc = 0;
    logic [7:0]       e_dir;
    logic [11:0]      e_fire;
    logic [1:0]       e_start, e_coin;

    function automatic logic [3:0] ref_rotate(input logic [3:0] d, input logic r, input logic [1:0] o);
        logic u, dn, l, rt;
        u = d[3]; dn = d[2]; l = d[1]; rt = d[0];
        if (r && !o[0]) begin u = d[1]; rt = d[3]; dn = d[0]; l = d[2]; end
        else if (r)     begin u = d[0]; l = d[3]; dn = d[1]; rt = d[2]; end
        if (o[1]) return {dn, u, rt, l};
        return {u, dn, l, rt};
    endfunction

    task automatic model_step();
        logic [15:0] w0, w1;
        if (RESET) begin
            for (int p = 0; p < PLAYERS; p++) begin
                m_s1[p] = '0; m_pd[p] = '0; m_po[p] = '0; m_pf[p] = '0;
                m_age[p] = 0; m_pc[p] = 1'b0; m_left[p] = 0; m_dead[p] = 0; m_wlow[p] = 0;
                for (int k = 0; k < 4; k++) m_t[p][k] = 0;
            end
            e_dir = '0; e_fire = '0; e_start = '0; e_coin = '0;
            return;
        end
        m_cyc++;
        for (int p = 0; p < PLAYERS; p++) begin
            logic [3:0] d, o;
            logic [FIRES-1:0] f;
            logic c, co, ph;
            // directions: newest press wins; one idle cycle before a loser comes back
            d = ref_rotate(m_s1[p][3:0], rotate, orientation);
            for (int k = 0; k < 4; k++) if (d[k] && !m_pd[p][k]) m_t[p][k] = m_cyc;
            o = '0;
            for (int ax = 0; ax < 2; ax++) begin
                int i, j;
                i = 2*ax; j = i + 1;
                if (d[i] && d[j]) begin
                    o[i] = m_t[p][i] > m_t[p][j];
                    o[j] = m_t[p][j] > m_t[p][i];
                end else if (d[i]) o[i] = !(m_pd[p][i] && m_po[p][j]);
                else if (d[j])     o[j] = !(m_pd[p][j] && m_po[p][i]);
            end
            m_pd[p] = d; m_po[p] = o;
            e_dir[4*p +: 4] = o;
            // autofire: age since last masked press, square wave of AF_HALF
            f = m_s1[p][4 +: FIRES];
            if (|(f & ~m_pf[p] & af_mask)) m_age[p] = 0;
            else if (|(f & af_mask))       m_age[p]++;
            else                           m_age[p] = 0;
            ph = ((m_age[p] / AF_HALF_I) % 2) == 0;
            e_fire[FIRES*p +: FIRES] = ph ? f : (f & ~af_mask);
            m_pf[p] = f;
            e_start[p] = m_s1[p][12];
            // coin: COIN_MIN-cycle pulse, one dead cycle, then wait for release
            c = m_s1[p][13];
            co = 1'b0;
            if (m_left[p] > 0) begin co = 1'b1; m_left[p]--; end
            else if (m_dead[p]) begin m_dead[p] = 0; m_wlow[p] = 1; end
            else if (m_wlow[p]) begin if (!c) m_wlow[p] = 0; end
            else if (c && !m_pc[p]) begin co = 1'b1; m_left[p] = COIN_MIN_I - 1; m_dead[p] = 1; end
            m_pc[p] = c;
            e_coin[p] = co;
        end
        w0 = joy_in[15:0]; w1 = joy_in[31:16];
        if (joyswap) begin w0 = joy_in[31:16]; w1 = joy_in[15:0]; end
        if (oneplayer) begin w0 = w0 | w1; w1 = '0; end
        m_s1[0] = w0; m_s1[1] = w1;
    endtask

    always @(posedge clk_sys) model_step();

    // ---------------- static vectors ----------------
    typedef struct {
        logic [31:0] joy;
        logic        rot;
        logic [1:0]  ori;
        logic        sw, one;
        logic [7:0]  dir;
        logic [11:0] fire;
        logic [1:0]  start;
    } vec_t;
    vec_t vt [13];

    initial begin
        int hi, rises;
        logic prev;
        vt[0]  = '{32'h0000_0008, 1'b0, 2'b00, 1'b0, 1'b0, 8'h08, 12'h000, 2'b00};
        vt[1]  = '{32'h0000_0002, 1'b1, 2'b00, 1'b0, 1'b0, 8'h08, 12'h000, 2'b00};
        vt[2]  = '{32'h0000_0002, 1'b1, 2'b10, 1'b0, 1'b0, 8'h04, 12'h000, 2'b00};
        vt[3]  = '{32'h0000_0002, 1'b1, 2'b01, 1'b0, 1'b0, 8'h04, 12'h000, 2'b00};
        vt[4]  = '{32'h0001_0000, 1'b0, 2'b10, 1'b0, 1'b0, 8'h20, 12'h000, 2'b00};
        vt[5]  = '{32'h0000_0008, 1'b1, 2'b00, 1'b0, 1'b0, 8'h01, 12'h000, 2'b00};
        vt[6]  = '{32'h0000_000B, 1'b0, 2'b00, 1'b0, 1'b0, 8'h08, 12'h000, 2'b00};
        vt[7]  = '{32'h1000_0000, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 12'h000, 2'b01};
        vt[8]  = '{32'h0008_0000, 1'b0, 2'b00, 1'b0, 1'b1, 8'h08, 12'h000, 2'b00};
        vt[9]  = '{32'h0004_0018, 1'b0, 2'b00, 1'b1, 1'b1, 8'h00, 12'h001, 2'b00};
        vt[10] = '{32'h0FF0_0000, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 12'hFC0, 2'b00};
        vt[11] = '{32'h1000_1000, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 12'h000, 2'b11};
        vt[12] = '{32'h0000_0008, 1'b1, 2'b11, 1'b0, 1'b0, 8'h01, 12'h000, 2'b00};

        RESET = 1'b1; joy_in = '0; rotate = 1'b0; orientation = 2'b00;
        joyswap = 1'b0; oneplayer = 1'b0; af_mask = '0;
        step(3);
        check("reset_dir",   32'(dir_out),   32'hFF);
        check("reset_fire",  32'(fire_out),  32'hFFF);
        check("reset_start", 32'(start_out), 32'h3);
        check("reset_coin",  32'(coin_out),  32'h3);

        // latency: up on P0 shows exactly two edges later
        RESET = 1'b0; step(2);
        joy_in = 32'h0000_0008;
        step(1); check("lat_edge1_up_raw", 32'(dir_out[3]), 32'h1);
        step(1); check("lat_edge2_up_raw", 32'(dir_out[3]), 32'h0);
        joy_in = '0; step(3);

        for (int v = 0; v < 13; v++) begin
            joy_in = '0; rotate = vt[v].rot; orientation = vt[v].ori;
            joyswap = vt[v].sw; oneplayer = vt[v].one;
            step(3);
            joy_in = vt[v].joy;
            step(2);
            check($sformatf("vec%0d_dir", v),   32'(dir_h),   32'(vt[v].dir));
            check($sformatf("vec%0d_fire", v),  32'(fire_h),  32'(vt[v].fire));
            check($sformatf("vec%0d_start", v), 32'(start_h), 32'(vt[v].start));
            check($sformatf("vec%0d_coin", v),  32'(coin_h),  32'h0);
        end
        joy_in = '0; rotate = 1'b0; orientation = 2'b00; joyswap = 1'b0; oneplayer = 1'b0;
        step(3);

        // SOCD sequence on P0 horizontal axis
        joy_in = 32'h1; step(2);
        check("socd_right", 32'(dir_h[3:0]), 32'h1);
        step(5);
        joy_in = 32'h3; step(2);
        check("socd_left_wins", 32'(dir_h[3:0]), 32'h2);
        joy_in = 32'h1; step(2);
        check("socd_gap", 32'(dir_h[3:0]), 32'h0);
        step(1);
        check("socd_right_back", 32'(dir_h[3:0]), 32'h1);
        joy_in = '0; step(3);
        joy_in = 32'h3; step(2);
        check("socd_tie", 32'(dir_h[3:0]), 32'h0);
        step(2);
        check("socd_tie_hold", 32'(dir_h[3:0]), 32'h0);
        joy_in = '0; step(3);

        // coin tap of one cycle on P1
        joy_in = 32'h2000_0000; step(1);
        joy_in = '0;
        check("coin_tap_not_yet", 32'(coin_h[1]), 32'h0);
        hi = 0; rises = 0; prev = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (k == 0) check("coin_tap_first", 32'(coin_h[1]), 32'h1);
            if (coin_h[1]) hi++;
            if (coin_h[1] && !prev) rises++;
            prev = coin_h[1];
        end
        check("coin_tap_len", 32'(hi), 32'(COIN_MIN_I));
        check("coin_tap_rises", 32'(rises), 32'h1);

        // coin held for 40 cycles gives one pulse only
        joy_in = 32'h2000_0000;
        hi = 0; rises = 0; prev = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (coin_h[1]) hi++;
            if (coin_h[1] && !prev) rises++;
            prev = coin_h[1];
        end
        check("coin_hold_len", 32'(hi), 32'(COIN_MIN_I));
        check("coin_hold_rises", 32'(rises), 32'h1);
        joy_in = '0; step(3);
        check("coin_released", 32'(coin_h[1]), 32'h0);
        joy_in = 32'h2000_0000; step(2);
        check("coin_repress", 32'(coin_h[1]), 32'h1);
        joy_in = '0; step(12);

        // autofire on fire A, fire B steady
        af_mask = 6'b000001;
        joy_in = 32'h0000_0010; step(1);
        for (int k = 0; k < 20; k++) begin
            step(1);
            check($sformatf("af_a_k%0d", k), 32'(fire_h[0]), 32'(((k / AF_HALF_I) % 2) == 0));
        end
        joy_in = '0; step(3);
        joy_in = 32'h0000_0020; step(2);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("af_b_k%0d", k), 32'(fire_h[1]), 32'h1);
            step(1);
        end
        joy_in = '0; af_mask = '0; step(3);

        // randomized traffic against the model
        RESET = 1'b1; step(2); RESET = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 2) == 0)
                joy_in = {16'($urandom) & 16'($urandom), 16'($urandom) & 16'($urandom)};
            if ($urandom_range(0, 49) == 0) begin
                rotate = 1'($urandom); orientation = 2'($urandom);
                joyswap = 1'($urandom); oneplayer = 1'($urandom);
            end
            if ($urandom_range(0, 39) == 0) af_mask = 6'($urandom);
            RESET = ($urandom_range(0, 299) == 0);
            step(1);
            check($sformatf("rnd%0d_dir", c),   32'(dir_h),   32'(e_dir));
            check($sformatf("rnd%0d_fire", c),  32'(fire_h),  32'(e_fire));
            check($sformatf("rnd%0d_start", c), 32'(start_h), 32'(e_start));
            check($sformatf("rnd%0d_coin", c),  32'(coin_h),  32'(e_coin));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
